// File: rtl/mul_pkg.sv
// Shared types and helpers for the M-extension multiply datapath.
package mul_pkg;

    // RISC-V M-extension multiply selects, encoded as the ALU presents them
    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    // Smallest configurations the datapath is built to handle
    localparam int MIN_XLEN        = 8;
    localparam int MIN_PIPE_STAGES = 1;

    // Every op except MUL returns the upper half of the double-width product
    function automatic logic is_high_half(input mul_op_e op);
        return (op != MUL);
    endfunction

    // rs1 is treated as signed by MULH and MULHSU
    function automatic logic rs1_is_signed(input mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    // rs2 is treated as signed only by MULH
    function automatic logic rs2_is_signed(input mul_op_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/mul_operand_extend.sv
// Maps a multiply op and its raw operands onto a signed XLEN+1 operand pair,
// so a single signed multiplier covers signed, unsigned and mixed forms.
// Purely combinational; intended to be shared with a future divider.
module mul_operand_extend
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mul_op_e                i_op,
    input  logic [XLEN-1:0]        i_rs1,
    input  logic [XLEN-1:0]        i_rs2,
    output logic signed [XLEN:0]   o_op_a,
    output logic signed [XLEN:0]   o_op_b
);

    logic w_a_ext;
    logic w_b_ext;

    // The extra top bit is a copy of the MSB for signed operands, zero otherwise
    assign w_a_ext = rs1_is_signed(i_op) & i_rs1[XLEN-1];
    assign w_b_ext = rs2_is_signed(i_op) & i_rs2[XLEN-1];

    assign o_op_a = $signed({w_a_ext, i_rs1});
    assign o_op_b = $signed({w_b_ext, i_rs2});

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU) with
// stall, flush and a caller tag carried alongside each op. Only the valid
// vector is reset so the data/tag stages stay free to map onto DSP/SRL.
module mul_pipe_unit
    import mul_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 4,
    parameter int TAG_W       = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  mul_op_e           i_op,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_rs2,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_result,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_completing_next_cycle,
    output logic              o_busy
);

    localparam int PROD_W = 2 * XLEN;

    typedef struct packed {
        logic               valid;
        mul_op_e            op;
        logic [TAG_W-1:0]   tag;
        logic [PROD_W-1:0]  product;
    } mul_stage_t;

    generate
        if (PIPE_STAGES < MIN_PIPE_STAGES || XLEN < MIN_XLEN) begin : g_bad_params
            $error("mul_pipe_unit: PIPE_STAGES must be >= 1 and XLEN >= 8");
        end
    endgenerate

    logic signed [XLEN:0]     w_op_a;
    logic signed [XLEN:0]     w_op_b;
    logic signed [PROD_W-1:0] w_product;
    mul_stage_t               w_cap;
    mul_stage_t               w_last;

    logic [PIPE_STAGES-1:0]   r_vld_p;
    mul_op_e                  r_op_p   [PIPE_STAGES];
    logic [TAG_W-1:0]         r_tag_p  [PIPE_STAGES];
    logic [PROD_W-1:0]        r_prod_p [PIPE_STAGES];

    mul_operand_extend #(
        .XLEN (XLEN)
    ) u_extend (
        .i_op   (i_op),
        .i_rs1  (i_rs1),
        .i_rs2  (i_rs2),
        .o_op_a (w_op_a),
        .o_op_b (w_op_b)
    );

    // Signed multiply; sign-extending to PROD_W first yields the low 2*XLEN
    // bits of the full (XLEN+1)x(XLEN+1) product directly
    assign w_product = PROD_W'(w_op_a) * PROD_W'(w_op_b);

    // Capture word for stage 0; a flushed presentation never becomes valid
    always_comb begin
        w_cap.valid   = i_valid & ~i_flush;
        w_cap.op      = i_op;
        w_cap.tag     = i_tag;
        w_cap.product = w_product;
    end

    // ---- valid vector: flush beats stall, stall freezes, else shift ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p <= '0;
        end else if (i_flush) begin
            r_vld_p <= '0;
        end else if (!i_stall) begin
            r_vld_p[0] <= w_cap.valid;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
        end
    end

    // ---- data/tag stages: no reset, advance whenever not stalled ----
    always_ff @(posedge i_clk) begin
        if (!i_stall) begin
            r_op_p[0]   <= w_cap.op;
            r_tag_p[0]  <= w_cap.tag;
            r_prod_p[0] <= w_cap.product;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_op_p[i]   <= r_op_p[i-1];
                r_tag_p[i]  <= r_tag_p[i-1];
                r_prod_p[i] <= r_prod_p[i-1];
            end
        end
    end

    // ---- last stage: half selection happens here, using the pipelined op ----
    always_comb begin
        w_last.valid   = r_vld_p[PIPE_STAGES-1];
        w_last.op      = r_op_p[PIPE_STAGES-1];
        w_last.tag     = r_tag_p[PIPE_STAGES-1];
        w_last.product = r_prod_p[PIPE_STAGES-1];
    end

    assign o_valid  = w_last.valid;
    assign o_result = !w_last.valid             ? '0 :
                      is_high_half(w_last.op)   ? w_last.product[PROD_W-1:XLEN] :
                                                  w_last.product[XLEN-1:0];
    assign o_tag    = w_last.valid ? w_last.tag : '0;
    assign o_busy   = |r_vld_p;

    // With a single stage the op completing next edge is the one being presented
    generate
        if (PIPE_STAGES > 1) begin : g_comp_deep
            assign o_completing_next_cycle = r_vld_p[PIPE_STAGES-2] & ~i_stall & ~i_flush;
        end else begin : g_comp_single
            assign o_completing_next_cycle = i_valid & ~i_stall & ~i_flush;
        end
    endgenerate

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Bench for mul_pipe_unit: directed scenarios on a 32-bit/4-stage instance
// and a 64-bit/1-stage instance, plus randomized runs against an
// arithmetic reference model.
module tb_mul_pipe_unit;
    import mul_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 32-bit, 4-stage instance
    logic        a_valid, a_stall, a_flush;
    mul_op_e     a_op;
    logic [31:0] a_rs1, a_rs2;
    logic [4:0]  a_tag;
    logic        a_o_valid, a_o_comp, a_o_busy;
    logic [31:0] a_o_result;
    logic [4:0]  a_o_tag;

    // 64-bit, 1-stage instance
    logic        b_valid, b_stall, b_flush;
    mul_op_e     b_op;
    logic [63:0] b_rs1, b_rs2;
    logic [4:0]  b_tag;
    logic        b_o_valid, b_o_comp, b_o_busy;
    logic [63:0] b_o_result;
    logic [4:0]  b_o_tag;

    int checks = 0;
    int errors = 0;

    mul_pipe_unit #(.XLEN(32), .PIPE_STAGES(4), .TAG_W(5)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_op(a_op),
        .i_rs1(a_rs1), .i_rs2(a_rs2), .i_tag(a_tag), .i_stall(a_stall),
        .i_flush(a_flush), .o_valid(a_o_valid), .o_result(a_o_result),
        .o_tag(a_o_tag), .o_completing_next_cycle(a_o_comp), .o_busy(a_o_busy)
    );

    mul_pipe_unit #(.XLEN(64), .PIPE_STAGES(1), .TAG_W(5)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_op(b_op),
        .i_rs1(b_rs1), .i_rs2(b_rs2), .i_tag(b_tag), .i_stall(b_stall),
        .i_flush(b_flush), .o_valid(b_o_valid), .o_result(b_o_result),
        .o_tag(b_o_tag), .o_completing_next_cycle(b_o_comp), .o_busy(b_o_busy)
    );

    // Reference: interpret operands as integers, multiply exactly, pick a half
    function automatic logic [63:0] ref_mul(input mul_op_e op, input logic [63:0] a,
                                            input logic [63:0] b, input int xlen);
        logic [131:0]        mask, ua, ub;
        logic signed [131:0] va, vb, p, r;
        mask = (132'd1 << xlen) - 132'd1;
        ua = {68'd0, a} & mask;
        ub = {68'd0, b} & mask;
        va = $signed(ua);
        vb = $signed(ub);
        if ((op == MULH || op == MULHSU) && a[xlen-1]) va = va - $signed(132'd1 << xlen);
        if (op == MULH && b[xlen-1]) vb = vb - $signed(132'd1 << xlen);
        p = va * vb;
        r = (op == MUL) ? p : (p >>> xlen);
        r = r & $signed(mask);
        return r[63:0];
    endfunction

    function automatic logic [63:0] pick_operand(input int xlen);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = '1;
            2: v = 64'd1 << (xlen - 1);
            3: v = (64'd1 << (xlen - 1)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        if (xlen < 64) v = v & ((64'd1 << xlen) - 64'd1);
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_valid = 0; a_stall = 0; a_flush = 0; a_op = MUL; a_rs1 = 0; a_rs2 = 0; a_tag = 0;
        b_valid = 0; b_stall = 0; b_flush = 0; b_op = MUL; b_rs1 = 0; b_rs2 = 0; b_tag = 0;
    endtask

    // One op on the 32-bit instance: check latency, result and tag
    task automatic run_a(input mul_op_e op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] tag, input logic [31:0] exp_res, input string name);
        int n;
        a_valid = 1; a_op = op; a_rs1 = x; a_rs2 = y; a_tag = tag;
        n = 0;
        do begin
            step;
            n++;
            a_valid = 0;
        end while (!a_o_valid && n < 20);
        checks++;
        if (!a_o_valid || n != 4) begin
            errors++; $display("FAIL %s latency: got %0d edges (valid=%b), want 4", name, n, a_o_valid);
        end
        checks++;
        if (a_o_result !== exp_res) begin
            errors++; $display("FAIL %s result: got %h want %h", name, a_o_result, exp_res);
        end
        checks++;
        if (a_o_tag !== tag) begin
            errors++; $display("FAIL %s tag: got %0d want %0d", name, a_o_tag, tag);
        end
        step;
        checks++;
        if (a_o_valid !== 1'b0) begin
            errors++; $display("FAIL %s single_pulse: o_valid got %b want 0", name, a_o_valid);
        end
    endtask

    // One op on the 64-bit, single-stage instance
    task automatic run_b(input mul_op_e op, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] tag, input logic [63:0] exp_res, input string name);
        b_valid = 1; b_op = op; b_rs1 = x; b_rs2 = y; b_tag = tag;
        #1;
        checks++;
        if (b_o_comp !== 1'b1) begin
            errors++; $display("FAIL %s completing_next: got %b want 1", name, b_o_comp);
        end
        step;
        b_valid = 0;
        checks++;
        if (b_o_valid !== 1'b1 || b_o_result !== exp_res || b_o_tag !== tag) begin
            errors++;
            $display("FAIL %s: valid=%b result=%h tag=%0d, want valid=1 result=%h tag=%0d",
                     name, b_o_valid, b_o_result, b_o_tag, exp_res, tag);
        end
        step;
        checks++;
        if (b_o_valid !== 1'b0) begin
            errors++; $display("FAIL %s single_pulse: o_valid got %b want 0", name, b_o_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        step;
        step;
        checks++;
        if ({a_o_valid, a_o_busy, a_o_comp} !== 3'b000 || a_o_result !== 32'd0 || a_o_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_a: valid=%b busy=%b comp=%b result=%h tag=%0d, want all 0",
                     a_o_valid, a_o_busy, a_o_comp, a_o_result, a_o_tag);
        end
        checks++;
        if ({b_o_valid, b_o_busy, b_o_comp} !== 3'b000 || b_o_result !== 64'd0 || b_o_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_b: valid=%b busy=%b comp=%b result=%h tag=%0d, want all 0",
                     b_o_valid, b_o_busy, b_o_comp, b_o_result, b_o_tag);
        end
        rst_n = 1;
        step;
    endtask

    task automatic test_unsigned;
        run_a(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, "mulhu_ones");
        run_a(MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, "mul_ones");
    endtask

    task automatic test_signed;
        run_a(MULH,   32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, "mulh_min");
        run_a(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, "mulhsu_ones");
        run_a(MULH,   32'hFFFF_FFFE, 32'h0000_0003, 5'd6, 32'hFFFF_FFFF, "mulh_neg");
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_res [4];
        logic        exp_comp, exp_v;
        int          e;
        exp_res[0] = 32'd6; exp_res[1] = 32'd20; exp_res[2] = 32'd42; exp_res[3] = 32'd72;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                a_valid = 1; a_op = MUL; a_rs1 = 32'(2 * (c + 1)); a_rs2 = 32'(2 * (c + 1) + 1);
                a_tag = 5'(c + 1);
            end else begin
                a_valid = 0;
            end
            #1;
            exp_comp = (c >= 3 && c <= 6);
            checks++;
            if (a_o_comp !== exp_comp) begin
                errors++; $display("FAIL b2b_comp c=%0d: got %b want %b", c, a_o_comp, exp_comp);
            end
            step;
            e = c + 1;
            exp_v = (e >= 4 && e <= 7);
            checks++;
            if (a_o_valid !== exp_v) begin
                errors++; $display("FAIL b2b_valid edge=%0d: got %b want %b", e, a_o_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (a_o_result !== exp_res[e-4] || a_o_tag !== 5'(e - 3)) begin
                    errors++;
                    $display("FAIL b2b_data edge=%0d: result=%0d tag=%0d want %0d tag=%0d",
                             e, a_o_result, a_o_tag, exp_res[e-4], e - 3);
                end
            end
            if (e <= 7) begin
                checks++;
                if (a_o_busy !== 1'b1) begin
                    errors++; $display("FAIL b2b_busy edge=%0d: got %b want 1", e, a_o_busy);
                end
            end
        end
    endtask

    task automatic test_stall;
        int   n;
        logic got, pre_comp, extra;
        a_valid = 1; a_op = MUL; a_rs1 = 32'd7; a_rs2 = 32'd11; a_tag = 5'd9;
        step;
        a_valid = 0;
        step;
        for (int k = 0; k < 3; k++) begin
            a_stall = 1; a_valid = 1; a_rs1 = 32'd1; a_rs2 = 32'd1; a_tag = 5'd10;
            #1;
            checks++;
            if (a_o_comp !== 1'b0) begin
                errors++; $display("FAIL stall_comp k=%0d: got %b want 0", k, a_o_comp);
            end
            step;
            checks++;
            if (a_o_valid !== 1'b0 || a_o_busy !== 1'b1) begin
                errors++; $display("FAIL stall_hold k=%0d: valid=%b busy=%b want 0/1", k, a_o_valid, a_o_busy);
            end
        end
        a_stall = 0; a_valid = 0;
        n = 5; got = 0; pre_comp = 0;
        while (!got && n < 20) begin
            #1;
            pre_comp = a_o_comp;
            step;
            n++;
            if (a_o_valid) got = 1;
        end
        checks++;
        if (!got || n != 7) begin
            errors++; $display("FAIL stall_latency: got %0d edges (seen=%b) want 7", n, got);
        end
        checks++;
        if (pre_comp !== 1'b1) begin
            errors++; $display("FAIL stall_comp_lead: got %b want 1", pre_comp);
        end
        checks++;
        if (a_o_result !== 32'd77 || a_o_tag !== 5'd9) begin
            errors++; $display("FAIL stall_data: result=%0d tag=%0d want 77 tag 9", a_o_result, a_o_tag);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            step;
            extra |= a_o_valid;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++; $display("FAIL stall_dropped_op: extra o_valid seen=%b want 0", extra);
        end
    endtask

    task automatic test_flush;
        logic extra;
        a_valid = 1; a_op = MUL; a_rs1 = 32'd3; a_rs2 = 32'd3; a_tag = 5'd1;
        step;
        a_rs1 = 32'd5; a_rs2 = 32'd5; a_tag = 5'd2;
        step;
        checks++;
        if (a_o_busy !== 1'b1) begin
            errors++; $display("FAIL flush_pre_busy: got %b want 1", a_o_busy);
        end
        a_flush = 1; a_stall = 1; a_rs1 = 32'd9; a_tag = 5'd3;
        step;
        a_flush = 0; a_stall = 0; a_valid = 0;
        checks++;
        if (a_o_busy !== 1'b0 || a_o_valid !== 1'b0) begin
            errors++; $display("FAIL flush_busy: busy=%b valid=%b want 0/0", a_o_busy, a_o_valid);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            step;
            extra |= a_o_valid | a_o_busy;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++; $display("FAIL flush_no_valid: activity seen=%b want 0", extra);
        end
    endtask

    task automatic test_async_reset;
        int   n;
        logic extra;
        for (int c = 0; c < 4; c++) begin
            a_valid = 1; a_op = MULHU; a_rs1 = 32'(c + 100); a_rs2 = 32'hF000_0000; a_tag = 5'(c);
            step;
        end
        a_valid = 0;
        n = 0;
        while (!a_o_valid && n < 10) begin
            step;
            n++;
        end
        checks++;
        if (a_o_valid !== 1'b1) begin
            errors++; $display("FAIL areset_setup: o_valid got %b want 1", a_o_valid);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (a_o_valid !== 1'b0 || a_o_result !== 32'd0 || a_o_tag !== 5'd0 || a_o_busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: valid=%b result=%h tag=%0d busy=%b want all 0",
                     a_o_valid, a_o_result, a_o_tag, a_o_busy);
        end
        step;
        step;
        rst_n = 1;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            step;
            extra |= a_o_valid | a_o_busy;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++; $display("FAIL areset_dropped: leftover activity=%b want 0", extra);
        end
        run_a(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, "post_reset_mulhu");
    endtask

    task automatic test_xlen64;
        run_b(MULHU, '1, '1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, "x64_mulhu");
        run_b(MUL,   '1, '1, 5'd7, 64'h0000_0000_0000_0001, "x64_mul");
        run_b(MULH,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8,
              64'h4000_0000_0000_0000, "x64_mulh_min");
    endtask

    // Random traffic with stalls; outputs must match the model in order
    task automatic test_random(input bit sel, input int ncycles);
        logic [63:0] q_res [$];
        logic [4:0]  q_tag [$];
        logic [63:0] x, y, exp_r, obs_r, pre_r;
        logic [4:0]  t, obs_t;
        mul_op_e     op;
        logic        v, s, obs_v, pre_v;
        int          xlen, drain;
        xlen = sel ? 64 : 32;
        for (int c = 0; c < ncycles + 30; c++) begin
            v  = (c < ncycles) && ($urandom_range(0, 9) < 6);
            s  = ($urandom_range(0, 3) == 0);
            op = mul_op_e'($urandom_range(0, 3));
            x  = pick_operand(xlen);
            y  = pick_operand(xlen);
            t  = 5'($urandom_range(0, 31));
            if (sel) begin
                b_valid = v; b_stall = s; b_op = op; b_rs1 = x; b_rs2 = y; b_tag = t;
            end else begin
                a_valid = v; a_stall = s; a_op = op; a_rs1 = x[31:0]; a_rs2 = y[31:0]; a_tag = t;
            end
            if (v && !s) begin
                q_res.push_back(ref_mul(op, x, y, xlen));
                q_tag.push_back(t);
            end
            pre_v = sel ? b_o_valid : a_o_valid;
            pre_r = sel ? b_o_result : {32'd0, a_o_result};
            step;
            obs_v = sel ? b_o_valid : a_o_valid;
            obs_r = sel ? b_o_result : {32'd0, a_o_result};
            obs_t = sel ? b_o_tag : a_o_tag;
            if (s) begin
                checks++;
                if (obs_v !== pre_v || obs_r !== pre_r) begin
                    errors++;
                    $display("FAIL rand%0d_stall_steady c=%0d: valid %b->%b result %h->%h",
                             xlen, c, pre_v, obs_v, pre_r, obs_r);
                end
            end else if (obs_v) begin
                checks++;
                if (q_res.size() == 0) begin
                    errors++; $display("FAIL rand%0d_unexpected c=%0d: result %h tag %0d with nothing pending",
                                       xlen, c, obs_r, obs_t);
                end else begin
                    exp_r = q_res.pop_front();
                    t     = q_tag.pop_front();
                    if (obs_r !== exp_r || obs_t !== t) begin
                        errors++;
                        $display("FAIL rand%0d_data c=%0d: result %h tag %0d want %h tag %0d",
                                 xlen, c, obs_r, obs_t, exp_r, t);
                    end
                end
            end
        end
        drain = q_res.size();
        checks++;
        if (drain != 0) begin
            errors++; $display("FAIL rand%0d_drain: %0d ops never completed, want 0", xlen, drain);
        end
        idle_inputs;
        step;
    endtask

    initial begin
        idle_inputs;
        test_reset;
        test_unsigned;
        test_signed;
        test_back_to_back;
        test_stall;
        test_flush;
        test_async_reset;
        test_xlen64;
        test_random(1'b0, 300);
        test_random(1'b1, 300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
